// File: rtl/register_file_p.sv
// Register file with two registered read ports, one write port, per-entry written tracking
// and an FSM-driven clear sweep. Define REGFILE_BYPASS_EN to forward same-edge writes to reads.
module register_file_p #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_en1,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic              rd_en2,
   input  logic [ADDR_W-1:0] rd_addr2,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              clr,
   output logic [DATA_W-1:0] rd_out1,
   output logic [DATA_W-1:0] rd_out2,
   output logic              rd_valid1,
   output logic              rd_valid2,
   output logic              rd_stale1,
   output logic              rd_stale2,
   output logic              wr_success,
   output logic              busy
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              wr_accept;
   logic              sweep;
   logic              hit1, hit2;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  written;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // A clr in IDLE wins over a same-cycle write; in CLEAR both wr_en and clr are ignored.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      wr_accept = 1'b0;
      sweep     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (clr) begin
               state_d = CLEAR;
               idx_d   = '0;
            end else begin
               wr_accept = wr_en;
            end
         end
         CLEAR: begin
            sweep = 1'b1;
            idx_d = idx_q + 1'b1;
            if (&idx_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q == CLEAR);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         written <= '0;
      end else if (sweep) begin
         mem[idx_q]     <= '0;
         written[idx_q] <= 1'b0;
      end else if (wr_accept) begin
         mem[wr_addr]     <= wr_data;
         written[wr_addr] <= 1'b1;
      end
   end

`ifdef REGFILE_BYPASS_EN
   always_comb begin
      hit1 = wr_accept && (wr_addr == rd_addr1);
      hit2 = wr_accept && (wr_addr == rd_addr2);
   end
`else
   always_comb begin
      hit1 = 1'b0;
      hit2 = 1'b0;
   end
`endif

   // rd_validN and wr_success are single-cycle pulses with no back-pressure: a request
   // sampled on edge N is always served and reported in the cycle following edge N.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_out1    <= '0;
         rd_out2    <= '0;
         rd_valid1  <= 1'b0;
         rd_valid2  <= 1'b0;
         rd_stale1  <= 1'b0;
         rd_stale2  <= 1'b0;
         wr_success <= 1'b0;
      end else begin
         rd_valid1  <= rd_en1;
         rd_valid2  <= rd_en2;
         wr_success <= wr_accept;
         if (rd_en1) begin
            rd_out1   <= hit1 ? wr_data : mem[rd_addr1];
            rd_stale1 <= hit1 ? 1'b0 : ~written[rd_addr1];
         end
         if (rd_en2) begin
            rd_out2   <= hit2 ? wr_data : mem[rd_addr2];
            rd_stale2 <= hit2 ? 1'b0 : ~written[rd_addr2];
         end
      end
   end

endmodule

// File: tb/tb_register_file_p.sv
// Self-checking bench for register_file_p: default 8x8 instance plus a 16-bit x 32-entry instance,
// with a behavioural model feeding per-port expected-read queues.
module tb_register_file_p;

   localparam int DW = 8;
   localparam int AW = 3;
   localparam int DEPTH = 8;
   localparam int WDW = 16;
   localparam int WAW = 5;
   localparam int WDEPTH = 32;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, rd_en1, rd_en2, wr_en, clr;
   logic [AW-1:0] rd_addr1, rd_addr2, wr_addr;
   logic [DW-1:0] wr_data, rd_out1, rd_out2;
   logic          rd_valid1, rd_valid2, rd_stale1, rd_stale2, wr_success, busy;

   logic           w_rd_en1, w_rd_en2, w_wr_en, w_clr;
   logic [WAW-1:0] w_rd_addr1, w_rd_addr2, w_wr_addr;
   logic [WDW-1:0] w_wr_data, w_rd_out1, w_rd_out2;
   logic           w_rd_valid1, w_rd_valid2, w_rd_stale1, w_rd_stale2, w_wr_success, w_busy;

   register_file_p #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst),
      .rd_en1(rd_en1), .rd_addr1(rd_addr1), .rd_en2(rd_en2), .rd_addr2(rd_addr2),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .clr(clr),
      .rd_out1(rd_out1), .rd_out2(rd_out2), .rd_valid1(rd_valid1), .rd_valid2(rd_valid2),
      .rd_stale1(rd_stale1), .rd_stale2(rd_stale2), .wr_success(wr_success), .busy(busy)
   );

   register_file_p #(.DATA_W(WDW), .ADDR_W(WAW)) dut_wide (
      .clk(clk), .rst(rst),
      .rd_en1(w_rd_en1), .rd_addr1(w_rd_addr1), .rd_en2(w_rd_en2), .rd_addr2(w_rd_addr2),
      .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data), .clr(w_clr),
      .rd_out1(w_rd_out1), .rd_out2(w_rd_out2), .rd_valid1(w_rd_valid1), .rd_valid2(w_rd_valid2),
      .rd_stale1(w_rd_stale1), .rd_stale2(w_rd_stale2), .wr_success(w_wr_success), .busy(w_busy)
   );

   int checks = 0;
   int errors = 0;

   // Expected read results: {stale, data}
   logic [DW:0]  exp_q1[$], exp_q2[$];
   logic [WDW:0] exp_w1[$], exp_w2[$];

   logic [DW-1:0]  mdl_mem[DEPTH];
   logic           mdl_wr[DEPTH];
   logic           mdl_clear;
   int             mdl_idx;
   logic [WDW-1:0] w_mdl_mem[WDEPTH];
   logic           w_mdl_wr[WDEPTH];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      rst = 1'b0; clr = 1'b0;
      rd_en1 = 1'b0; rd_addr1 = '0; rd_en2 = 1'b0; rd_addr2 = '0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      w_rd_en1 = 1'b0; w_rd_addr1 = '0; w_rd_en2 = 1'b0; w_rd_addr2 = '0;
      w_wr_en = 1'b0; w_wr_addr = '0; w_wr_data = '0;
   endtask

   task automatic step();
      logic was_rst, en1, en2, wen1, wen2, exp_ws, exp_wws;
      logic [DW:0]  e;
      logic [WDW:0] we;
      was_rst = rst;
      en1 = rd_en1 && !rst;
      en2 = rd_en2 && !rst;
      wen1 = w_rd_en1 && !rst;
      wen2 = w_rd_en2 && !rst;
      exp_ws = !rst && !mdl_clear && !clr && wr_en;
      exp_wws = !rst && !w_clr && w_wr_en;
      if (en1) begin
         if (BYPASS && exp_ws && wr_addr == rd_addr1) e = {1'b0, wr_data};
         else e = {!mdl_wr[rd_addr1], mdl_mem[rd_addr1]};
         exp_q1.push_back(e);
      end
      if (en2) begin
         if (BYPASS && exp_ws && wr_addr == rd_addr2) e = {1'b0, wr_data};
         else e = {!mdl_wr[rd_addr2], mdl_mem[rd_addr2]};
         exp_q2.push_back(e);
      end
      if (wen1) begin
         if (BYPASS && exp_wws && w_wr_addr == w_rd_addr1) we = {1'b0, w_wr_data};
         else we = {!w_mdl_wr[w_rd_addr1], w_mdl_mem[w_rd_addr1]};
         exp_w1.push_back(we);
      end
      if (wen2) begin
         if (BYPASS && exp_wws && w_wr_addr == w_rd_addr2) we = {1'b0, w_wr_data};
         else we = {!w_mdl_wr[w_rd_addr2], w_mdl_mem[w_rd_addr2]};
         exp_w2.push_back(we);
      end
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin mdl_mem[i] = '0; mdl_wr[i] = 1'b0; end
         for (int i = 0; i < WDEPTH; i++) begin w_mdl_mem[i] = '0; w_mdl_wr[i] = 1'b0; end
         mdl_clear = 1'b0;
         mdl_idx = 0;
      end else begin
         if (mdl_clear) begin
            mdl_mem[mdl_idx] = '0;
            mdl_wr[mdl_idx] = 1'b0;
            if (mdl_idx == DEPTH - 1) mdl_clear = 1'b0;
            else mdl_idx++;
         end else if (clr) begin
            mdl_clear = 1'b1;
            mdl_idx = 0;
         end else if (wr_en) begin
            mdl_mem[wr_addr] = wr_data;
            mdl_wr[wr_addr] = 1'b1;
         end
         if (exp_wws) begin
            w_mdl_mem[w_wr_addr] = w_wr_data;
            w_mdl_wr[w_wr_addr] = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      check("busy", 32'(busy), 32'(mdl_clear));
      check("wr_success", 32'(wr_success), 32'(exp_ws));
      check("rd_valid1", 32'(rd_valid1), 32'(en1));
      check("rd_valid2", 32'(rd_valid2), 32'(en2));
      check("w_wr_success", 32'(w_wr_success), 32'(exp_wws));
      if (rd_valid1) begin
         check("rd1_pending", 32'(exp_q1.size() > 0), 32'd1);
         if (exp_q1.size() > 0) begin
            e = exp_q1.pop_front();
            check("rd_out1", 32'(rd_out1), 32'(e[DW-1:0]));
            check("rd_stale1", 32'(rd_stale1), 32'(e[DW]));
         end
      end
      if (rd_valid2) begin
         check("rd2_pending", 32'(exp_q2.size() > 0), 32'd1);
         if (exp_q2.size() > 0) begin
            e = exp_q2.pop_front();
            check("rd_out2", 32'(rd_out2), 32'(e[DW-1:0]));
            check("rd_stale2", 32'(rd_stale2), 32'(e[DW]));
         end
      end
      if (w_rd_valid1) begin
         check("w_rd1_pending", 32'(exp_w1.size() > 0), 32'd1);
         if (exp_w1.size() > 0) begin
            we = exp_w1.pop_front();
            check("w_rd_out1", 32'(w_rd_out1), 32'(we[WDW-1:0]));
            check("w_rd_stale1", 32'(w_rd_stale1), 32'(we[WDW]));
         end
      end
      if (w_rd_valid2) begin
         check("w_rd2_pending", 32'(exp_w2.size() > 0), 32'd1);
         if (exp_w2.size() > 0) begin
            we = exp_w2.pop_front();
            check("w_rd_out2", 32'(w_rd_out2), 32'(we[WDW-1:0]));
            check("w_rd_stale2", 32'(w_rd_stale2), 32'(we[WDW]));
         end
      end
      if (was_rst) begin
         check("rst_rd_out1", 32'(rd_out1), 32'd0);
         check("rst_rd_out2", 32'(rd_out2), 32'd0);
         check("rst_stale", 32'({rd_stale1, rd_stale2}), 32'd0);
         check("rst_w_outs", 32'({w_rd_out1, w_rd_out2, w_rd_valid1, w_rd_valid2, w_busy}), 32'd0);
      end
   endtask

   task automatic do_write(input int addr, input int data);
      idle_inputs();
      wr_en = 1'b1; wr_addr = AW'(addr); wr_data = DW'(data);
      step();
   endtask

   task automatic fill_all();
      for (int i = 0; i < DEPTH; i++) do_write(i, 8'h10 + i);
   endtask

   initial begin
      mdl_clear = 1'b0;
      mdl_idx = 0;
      w_clr = 1'b0;
      idle_inputs();
      rst = 1'b1;
      step();
      step();

      // Unwritten entry on both ports
      idle_inputs();
      rd_en1 = 1'b1; rd_addr1 = 3'd3; rd_en2 = 1'b1; rd_addr2 = 3'd3;
      step();

      // Write then read back
      do_write(1, 8'h03);
      idle_inputs();
      rd_en1 = 1'b1; rd_addr1 = 3'd1;
      step();

      // Same-edge read/write to one address, then the follow-up read
      idle_inputs();
      wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h05; rd_en2 = 1'b1; rd_addr2 = 3'd2;
      step();
      idle_inputs();
      rd_en2 = 1'b1; rd_addr2 = 3'd2;
      step();
      idle_inputs();
      step();

      // Random traffic without clears
      for (int n = 0; n < 40; n++) begin
         idle_inputs();
         rd_en1 = 1'($urandom_range(0, 1)); rd_addr1 = AW'($urandom_range(0, DEPTH - 1));
         rd_en2 = 1'($urandom_range(0, 1)); rd_addr2 = AW'($urandom_range(0, DEPTH - 1));
         wr_en = 1'($urandom_range(0, 1));  wr_addr = AW'($urandom_range(0, DEPTH - 1));
         wr_data = DW'($urandom_range(0, 255));
         step();
      end

      // Full sweep: clr wins over the same-cycle write; reads of the swept entry see old data
      fill_all();
      idle_inputs();
      clr = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'hAA;
      step();
      for (int n = 0; n < DEPTH; n++) begin
         idle_inputs();
         rd_en1 = 1'b1; rd_addr1 = AW'(mdl_idx);
         rd_en2 = 1'b1; rd_addr2 = AW'($urandom_range(0, DEPTH - 1));
         wr_en = 1'b1; wr_addr = AW'($urandom_range(0, DEPTH - 1)); wr_data = 8'h77;
         clr = (n == 2);
         step();
      end
      for (int i = 0; i < DEPTH; i++) begin
         idle_inputs();
         rd_en1 = 1'b1; rd_addr1 = AW'(i); rd_en2 = 1'b1; rd_addr2 = AW'(DEPTH - 1 - i);
         step();
      end

      // Reset on the 4th sweep cycle, then a write and readback of entry 7
      fill_all();
      idle_inputs();
      clr = 1'b1;
      step();
      idle_inputs();
      for (int n = 0; n < 3; n++) step();
      rst = 1'b1; rd_en1 = 1'b1; rd_addr1 = 3'd5; wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'h44;
      step();
      do_write(7, 8'h7E);
      idle_inputs();
      rd_en1 = 1'b1; rd_addr1 = 3'd7; rd_en2 = 1'b1; rd_addr2 = 3'd4;
      step();

      // Wide instance: top entry round trip
      idle_inputs();
      w_wr_en = 1'b1; w_wr_addr = 5'd31; w_wr_data = 16'hBEEF;
      step();
      idle_inputs();
      w_rd_en1 = 1'b1; w_rd_addr1 = 5'd31; w_rd_en2 = 1'b1; w_rd_addr2 = 5'd31;
      step();
      idle_inputs();
      w_rd_en1 = 1'b1; w_rd_addr1 = 5'd30;
      step();

      idle_inputs();
      step();
      check("drain_q1", 32'(exp_q1.size()), 32'd0);
      check("drain_q2", 32'(exp_q2.size()), 32'd0);
      check("drain_w", 32'(exp_w1.size() + exp_w2.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
